// File: rtl/link_table_mgr.sv
// rtl/link_table_mgr.sv - multi-table linked-list manager over a shared node pool
// Orders walk the selected list one hop per cycle, then update pool arrays in a single EXEC cycle.
module link_table_mgr #(
  parameter int DATA_WIDTH  = 16,
  parameter int TABLE_WIDTH = 2,
  parameter int TABLE_NUM   = 4,
  parameter int DEPTH_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   order_valid,
  output logic                   order_busy,
  input  logic [2:0]             order_type,
  input  logic [TABLE_WIDTH-1:0] order_table,
  input  logic [DEPTH_WIDTH:0]   order_node,
  input  logic [DATA_WIDTH-1:0]  order_data,
  output logic                   dout_valid,
  input  logic                   dout_busy,
  output logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   dout_err
);
  localparam int NODES  = 2**DEPTH_WIDTH;
  localparam int TABLES = 2**TABLE_WIDTH;
  localparam logic [DEPTH_WIDTH:0] NODES_L = (DEPTH_WIDTH+1)'(NODES);
  localparam logic [DEPTH_WIDTH:0] ONE_L   = (DEPTH_WIDTH+1)'(1);
  localparam logic [TABLE_WIDTH:0] TNUM_L  = (TABLE_WIDTH+1)'(TABLE_NUM);

  localparam logic [2:0] T_APPE = 3'd0;
  localparam logic [2:0] T_DELE = 3'd1;
  localparam logic [2:0] T_CHAG = 3'd2;
  localparam logic [2:0] T_READ = 3'd3;
  localparam logic [2:0] T_LEN  = 3'd4;
  localparam logic [2:0] T_CLR  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WALK, S_EXEC, S_RESP} state_t;

  state_t                  r_state;
  logic [2:0]              r_type;
  logic [TABLE_WIDTH-1:0]  r_table;
  logic [DEPTH_WIDTH:0]    r_pos;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_err;
  logic [DEPTH_WIDTH-1:0]  r_cursor;
  logic [DEPTH_WIDTH:0]    r_hops;
  logic [DEPTH_WIDTH:0]    r_len  [TABLES];
  logic [DEPTH_WIDTH-1:0]  r_head [TABLES];
  logic [DEPTH_WIDTH:0]    r_alloc_ptr;
  logic [DEPTH_WIDTH-1:0]  r_free_head;
  logic [DEPTH_WIDTH:0]    r_free_cnt;
  logic                    r_order_busy;
  logic                    r_dout_valid;
  logic [DATA_WIDTH-1:0]   r_dout_data;
  logic                    r_dout_err;
  logic [DEPTH_WIDTH-1:0]  r_next [NODES];
  logic [DATA_WIDTH-1:0]   r_mem  [NODES];

  logic [DEPTH_WIDTH:0]    w_len;
  logic [DEPTH_WIDTH-1:0]  w_head;
  logic                    w_tbl_ok;
  logic                    w_pool_empty;
  logic                    w_err;
  logic [DEPTH_WIDTH:0]    w_hops;
  logic [DEPTH_WIDTH-1:0]  w_new_node;
  logic [DEPTH_WIDTH-1:0]  w_cur_next;
  logic [DEPTH_WIDTH-1:0]  w_victim;
  logic [DEPTH_WIDTH-1:0]  w_victim_next;
  logic                    w_nx0_we, w_nx1_we, w_mem_we;
  logic [DEPTH_WIDTH-1:0]  w_nx0_addr, w_nx0_data, w_nx1_addr, w_nx1_data, w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_data;

  assign order_busy = r_order_busy;
  assign dout_valid = r_dout_valid;
  assign dout_data  = r_dout_data;
  assign dout_err   = r_dout_err;

  always_comb begin
    w_len        = r_len[r_table];
    w_head       = r_head[r_table];
    w_tbl_ok     = ({1'b0, r_table} < TNUM_L);
    w_pool_empty = (r_alloc_ptr == NODES_L) && (r_free_cnt == '0);
    w_new_node   = (r_free_cnt != '0) ? r_free_head : r_alloc_ptr[DEPTH_WIDTH-1:0];
    w_cur_next   = r_next[r_cursor];
    // For p=0 the cursor already sits on the head, otherwise on the predecessor.
    w_victim      = (r_pos == '0) ? r_cursor : w_cur_next;
    w_victim_next = r_next[w_victim];

    case (r_type)
      T_APPE:                 w_err = (r_pos > w_len) || w_pool_empty;
      T_DELE, T_CHAG, T_READ: w_err = (r_pos >= w_len);
      T_LEN, T_CLR:           w_err = 1'b0;
      default:                w_err = 1'b1;
    endcase
    if (!w_tbl_ok) w_err = 1'b1;

    case (r_type)
      T_READ, T_CHAG: w_hops = r_pos;
      T_APPE, T_DELE: w_hops = (r_pos == '0) ? '0 : r_pos - ONE_L;
      T_CLR:          w_hops = w_len;
      default:        w_hops = '0;
    endcase
    if (w_err) w_hops = '0;
  end

  always_comb begin
    w_nx0_we   = 1'b0;
    w_nx0_addr = r_cursor;
    w_nx0_data = r_free_head;
    w_nx1_we   = 1'b0;
    w_nx1_addr = r_cursor;
    w_nx1_data = w_new_node;
    w_mem_we   = 1'b0;
    w_mem_addr = r_cursor;
    w_mem_data = r_data;
    if (r_state == S_WALK && r_type == T_CLR) begin
      w_nx0_we = 1'b1;
    end else if (r_state == S_EXEC && !r_err) begin
      case (r_type)
        T_APPE: begin
          w_nx0_we   = 1'b1;
          w_nx0_addr = w_new_node;
          w_nx0_data = (r_pos == '0) ? r_cursor : w_cur_next;
          w_nx1_we   = (r_pos != '0);
          w_mem_we   = 1'b1;
          w_mem_addr = w_new_node;
        end
        T_DELE: begin
          w_nx0_we   = 1'b1;
          w_nx0_addr = w_victim;
          w_nx1_we   = (r_pos != '0);
          w_nx1_data = w_victim_next;
        end
        T_CHAG:  w_mem_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_nx0_we) r_next[w_nx0_addr] <= w_nx0_data;
    if (w_nx1_we) r_next[w_nx1_addr] <= w_nx1_data;
    if (w_mem_we) r_mem[w_mem_addr]  <= w_mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_type       <= '0;
      r_table      <= '0;
      r_pos        <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_cursor     <= '0;
      r_hops       <= '0;
      r_alloc_ptr  <= '0;
      r_free_head  <= '0;
      r_free_cnt   <= '0;
      r_order_busy <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      r_dout_err   <= 1'b0;
      for (int i = 0; i < TABLES; i++) begin
        r_len[i]  <= '0;
        r_head[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (order_valid) begin
            r_type       <= order_type;
            r_table      <= order_table;
            r_pos        <= order_node;
            r_data       <= order_data;
            r_order_busy <= 1'b1;
            r_state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err    <= w_err;
          r_cursor <= w_head;
          r_hops   <= w_hops;
          r_state  <= (w_hops == '0) ? S_EXEC : S_WALK;
        end
        S_WALK: begin
          r_cursor <= w_cur_next;
          r_hops   <= r_hops - ONE_L;
          if (r_type == T_CLR) begin
            r_free_head <= r_cursor;
            r_free_cnt  <= r_free_cnt + ONE_L;
          end
          if (r_hops == ONE_L) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state      <= S_RESP;
          r_dout_valid <= 1'b1;
          r_dout_err   <= r_err;
          r_dout_data  <= '0;
          if (!r_err) begin
            case (r_type)
              T_APPE: begin
                if (r_free_cnt != '0) begin
                  r_free_head <= r_next[r_free_head];
                  r_free_cnt  <= r_free_cnt - ONE_L;
                end else if (r_alloc_ptr != NODES_L) begin
                  r_alloc_ptr <= r_alloc_ptr + ONE_L;
                end
                if (r_pos == '0) r_head[r_table] <= w_new_node;
                r_len[r_table] <= w_len + ONE_L;
              end
              T_DELE: begin
                if (r_pos == '0) r_head[r_table] <= w_victim_next;
                r_free_head    <= w_victim;
                r_free_cnt     <= r_free_cnt + ONE_L;
                r_len[r_table] <= w_len - ONE_L;
                r_dout_data    <= r_mem[w_victim];
              end
              T_CHAG, T_READ: r_dout_data <= r_mem[r_cursor];
              T_LEN:          r_dout_data <= DATA_WIDTH'(w_len);
              T_CLR: begin
                r_len[r_table] <= '0;
                r_dout_data    <= DATA_WIDTH'(w_len);
              end
              default: ;
            endcase
          end
        end
        S_RESP: begin
          if (!dout_busy) begin
            r_dout_valid <= 1'b0;
            r_order_busy <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_link_table_mgr.sv
// tb/tb_link_table_mgr.sv - directed self-checking bench for link_table_mgr
// A second instance with TABLE_NUM=3 covers the out-of-range table check.
module tb_link_table_mgr;
  localparam logic [2:0] APPE = 3'd0, DELE = 3'd1, CHAG = 3'd2, READ = 3'd3, LEN = 3'd4, CLR = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        order_valid = 1'b0;
  logic        order_busy;
  logic [2:0]  order_type = '0;
  logic [1:0]  order_table = '0;
  logic [6:0]  order_node = '0;
  logic [15:0] order_data = '0;
  logic        dout_valid;
  logic        dout_busy = 1'b0;
  logic [15:0] dout_data;
  logic        dout_err;

  logic        order_valid3 = 1'b0;
  logic        order_busy3;
  logic [2:0]  order_type3 = '0;
  logic [1:0]  order_table3 = '0;
  logic        dout_valid3;
  logic [15:0] dout_data3;
  logic        dout_err3;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] rd;
  logic        re;
  int          lat;

  always #5 clk = ~clk;

  link_table_mgr u_dut (
    .clk(clk), .rst_n(rst_n), .order_valid(order_valid), .order_busy(order_busy),
    .order_type(order_type), .order_table(order_table), .order_node(order_node),
    .order_data(order_data), .dout_valid(dout_valid), .dout_busy(dout_busy),
    .dout_data(dout_data), .dout_err(dout_err)
  );

  link_table_mgr #(.TABLE_NUM(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .order_valid(order_valid3), .order_busy(order_busy3),
    .order_type(order_type3), .order_table(order_table3), .order_node(7'd0),
    .order_data(16'd0), .dout_valid(dout_valid3), .dout_busy(1'b0),
    .dout_data(dout_data3), .dout_err(dout_err3)
  );

  task automatic do_order(input logic [2:0] t, input logic [1:0] tb, input logic [6:0] p,
                          input logic [15:0] d, output logic [15:0] o_data, output logic o_err,
                          output int o_lat);
    int n;
    @(negedge clk);
    order_valid = 1'b1; order_type = t; order_table = tb; order_node = p; order_data = d;
    @(posedge clk); #1;
    order_valid = 1'b0;
    n = 0;
    while (!dout_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!dout_valid) begin
      n_assert++; n_fail++;
      $display("FAIL order_timeout: type %0d table %0d got no response, required dout_valid=1", t, tb);
    end
    o_data = dout_data; o_err = dout_err; o_lat = n;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_assert++; if (order_busy !== 1'b0) begin n_fail++; $display("FAIL reset_order_busy: got %b required 0", order_busy); end
    n_assert++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b required 0", dout_valid); end
    n_assert++; if (dout_data !== 16'd0) begin n_fail++; $display("FAIL reset_dout_data: got %0d required 0", dout_data); end
    n_assert++; if (dout_err !== 1'b0) begin n_fail++; $display("FAIL reset_dout_err: got %b required 0", dout_err); end
  endtask

  task automatic test_append_read();
    for (int i = 0; i < 3; i++) begin
      do_order(APPE, 2'd3, 7'(i), 16'(111 + i), rd, re, lat);
      n_assert++; if (re !== 1'b0 || rd !== 16'd0) begin n_fail++; $display("FAIL appe3_%0d: got err %b data %0d required err 0 data 0", i, re, rd); end
    end
    do_order(LEN, 2'd3, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd3 || re !== 1'b0) begin n_fail++; $display("FAIL len3: got %0d err %b required 3 err 0", rd, re); end
    do_order(READ, 2'd3, 7'd2, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd113) begin n_fail++; $display("FAIL read3_2: got %0d required 113", rd); end
    n_assert++; if (lat != 4) begin n_fail++; $display("FAIL read_latency: got %0d required 4", lat); end
    do_order(READ, 2'd3, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd111) begin n_fail++; $display("FAIL read3_0: got %0d required 111", rd); end
  endtask

  task automatic test_delete_reuse();
    do_order(DELE, 2'd3, 7'd2, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd113 || re !== 1'b0) begin n_fail++; $display("FAIL dele3_2: got %0d err %b required 113 err 0", rd, re); end
    do_order(LEN, 2'd3, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd2) begin n_fail++; $display("FAIL len3_after_dele: got %0d required 2", rd); end
    do_order(APPE, 2'd1, 7'd0, 16'd20, rd, re, lat);
    n_assert++; if (u_dut.r_alloc_ptr !== 7'd3) begin n_fail++; $display("FAIL reuse_alloc_ptr: got %0d required 3", u_dut.r_alloc_ptr); end
    do_order(READ, 2'd1, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd20) begin n_fail++; $display("FAIL read1_0: got %0d required 20", rd); end
    do_order(READ, 2'd3, 7'd1, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd112) begin n_fail++; $display("FAIL read3_1: got %0d required 112", rd); end
  endtask

  task automatic test_insert_change();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'd6; exp_v[1] = 16'd7; exp_v[2] = 16'd5;
    do_order(APPE, 2'd2, 7'd0, 16'd5, rd, re, lat);
    do_order(APPE, 2'd2, 7'd0, 16'd6, rd, re, lat);
    do_order(APPE, 2'd2, 7'd1, 16'd7, rd, re, lat);
    for (int i = 0; i < 3; i++) begin
      do_order(READ, 2'd2, 7'(i), 16'd0, rd, re, lat);
      n_assert++; if (rd !== exp_v[i]) begin n_fail++; $display("FAIL insert_read2_%0d: got %0d required %0d", i, rd, exp_v[i]); end
    end
    do_order(CHAG, 2'd2, 7'd1, 16'd9, rd, re, lat);
    n_assert++; if (rd !== 16'd7 || re !== 1'b0) begin n_fail++; $display("FAIL chag2_1: got %0d err %b required 7 err 0", rd, re); end
    do_order(READ, 2'd2, 7'd1, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd9) begin n_fail++; $display("FAIL read2_1_after_chag: got %0d required 9", rd); end
  endtask

  task automatic test_errors();
    do_order(READ, 2'd0, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (re !== 1'b1 || rd !== 16'd0) begin n_fail++; $display("FAIL err_read_empty: got err %b data %0d required err 1 data 0", re, rd); end
    do_order(APPE, 2'd0, 7'd2, 16'd1, rd, re, lat);
    n_assert++; if (re !== 1'b1 || rd !== 16'd0) begin n_fail++; $display("FAIL err_appe_pos: got err %b data %0d required err 1 data 0", re, rd); end
    do_order(LEN, 2'd0, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd0) begin n_fail++; $display("FAIL err_len0: got %0d required 0", rd); end
    do_order(3'd7, 2'd2, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (re !== 1'b1 || rd !== 16'd0) begin n_fail++; $display("FAIL err_type7: got err %b data %0d required err 1 data 0", re, rd); end
    n_assert++; if (lat != 2) begin n_fail++; $display("FAIL err_latency: got %0d required 2", lat); end
    do_order(DELE, 2'd2, 7'd3, 16'd0, rd, re, lat);
    n_assert++; if (re !== 1'b1) begin n_fail++; $display("FAIL err_dele_pos_eq_len: got err %b required 1", re); end
    do_order(LEN, 2'd2, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd3) begin n_fail++; $display("FAIL err_len2: got %0d required 3", rd); end
  endtask

  task automatic test_table_range();
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      order_valid3 = 1'b1; order_type3 = LEN; order_table3 = (k == 0) ? 2'd3 : 2'd2;
      @(posedge clk); #1;
      order_valid3 = 1'b0;
      n = 0;
      while (!dout_valid3 && n < 50) begin @(posedge clk); #1; n++; end
      n_assert++;
      if (k == 0 && (dout_valid3 !== 1'b1 || dout_err3 !== 1'b1 || dout_data3 !== 16'd0)) begin
        n_fail++; $display("FAIL table_range_t3: got valid %b err %b data %0d required 1 1 0", dout_valid3, dout_err3, dout_data3);
      end
      if (k == 1 && (dout_valid3 !== 1'b1 || dout_err3 !== 1'b0 || dout_data3 !== 16'd0)) begin
        n_fail++; $display("FAIL table_range_t2: got valid %b err %b data %0d required 1 0 0", dout_valid3, dout_err3, dout_data3);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clear();
    do_order(APPE, 2'd3, 7'd2, 16'd114, rd, re, lat);
    do_order(CLR, 2'd3, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd3 || re !== 1'b0) begin n_fail++; $display("FAIL clr3: got %0d err %b required 3 err 0", rd, re); end
    n_assert++; if (lat != 5) begin n_fail++; $display("FAIL clr_latency: got %0d required 5", lat); end
    do_order(LEN, 2'd3, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd0) begin n_fail++; $display("FAIL clr_len3: got %0d required 0", rd); end
    for (int i = 0; i < 3; i++) begin
      do_order(APPE, 2'd0, 7'(i), 16'(200 + i), rd, re, lat);
      n_assert++; if (re !== 1'b0) begin n_fail++; $display("FAIL clr_reappe_%0d: got err %b required 0", i, re); end
    end
    n_assert++; if (u_dut.r_alloc_ptr !== 7'd7) begin n_fail++; $display("FAIL clr_alloc_ptr: got %0d required 7", u_dut.r_alloc_ptr); end
    do_order(READ, 2'd0, 7'd2, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd202) begin n_fail++; $display("FAIL clr_read0_2: got %0d required 202", rd); end
  endtask

  task automatic test_exhaust();
    int bad = 0;
    for (int i = 0; i < 57; i++) begin
      do_order(APPE, 2'd1, 7'd0, 16'(1000 + i), rd, re, lat);
      if (re !== 1'b0) bad++;
    end
    n_assert++; if (bad != 0) begin n_fail++; $display("FAIL fill_pool: got %0d rejected appends required 0", bad); end
    do_order(APPE, 2'd1, 7'd0, 16'd55, rd, re, lat);
    n_assert++; if (re !== 1'b1 || rd !== 16'd0) begin n_fail++; $display("FAIL err_pool_full: got err %b data %0d required err 1 data 0", re, rd); end
    do_order(LEN, 2'd1, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd58) begin n_fail++; $display("FAIL full_len1: got %0d required 58", rd); end
    do_order(DELE, 2'd1, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd1056) begin n_fail++; $display("FAIL dele1_head: got %0d required 1056", rd); end
    do_order(APPE, 2'd1, 7'd0, 16'd777, rd, re, lat);
    n_assert++; if (re !== 1'b0) begin n_fail++; $display("FAIL appe_after_free: got err %b required 0", re); end
    n_assert++; if (u_dut.r_alloc_ptr !== 7'd64) begin n_fail++; $display("FAIL alloc_saturate: got %0d required 64", u_dut.r_alloc_ptr); end
    do_order(READ, 2'd1, 7'd0, 16'd0, rd, re, lat);
    n_assert++; if (rd !== 16'd777) begin n_fail++; $display("FAIL read1_0_refill: got %0d required 777", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    dout_busy = 1'b1;
    @(negedge clk);
    order_valid = 1'b1; order_type = READ; order_table = 2'd2; order_node = 7'd0;
    @(posedge clk); #1;
    order_valid = 1'b0;
    n = 0;
    while (!dout_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      n_assert++;
      if (dout_valid !== 1'b1 || dout_data !== 16'd6 || order_busy !== 1'b1) begin
        n_fail++; $display("FAIL stall_cycle_%0d: got valid %b data %0d busy %b required 1 6 1", c, dout_valid, dout_data, order_busy);
      end
      @(posedge clk); #1;
    end
    dout_busy = 1'b0;
    @(posedge clk); #1;
    n_assert++; if (dout_valid !== 1'b0 || order_busy !== 1'b0) begin n_fail++; $display("FAIL stall_release: got valid %b busy %b required 0 0", dout_valid, order_busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    order_valid = 1'b1; order_type = READ; order_table = 2'd2; order_node = 7'd2;
    @(posedge clk); #1;
    order_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (order_busy !== 1'b0 || dout_valid !== 1'b0 || dout_data !== 16'd0 || dout_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got busy %b valid %b data %0d err %b required all 0", order_busy, dout_valid, dout_data, dout_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_assert++; if (u_dut.r_alloc_ptr !== 7'd0) begin n_fail++; $display("FAIL reset_mid_alloc: got %0d required 0", u_dut.r_alloc_ptr); end
    for (int t = 0; t < 4; t++) begin
      do_order(LEN, 2'(t), 7'd0, 16'd0, rd, re, lat);
      n_assert++; if (rd !== 16'd0 || re !== 1'b0) begin n_fail++; $display("FAIL reset_mid_len%0d: got %0d err %b required 0 err 0", t, rd, re); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_table_range();
    test_append_read();
    test_delete_reuse();
    test_insert_change();
    test_errors();
    test_clear();
    test_exhaust();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/link_table_mgr.md
Name: link_table_mgr

Overview:
- Parametrised successor to `link_top`: a multi-table linked-list manager with a shared node pool.
- The pool is backed by internal next-pointer and data arrays. A bump allocator hands out never-used nodes; a free list recycles released ones.
- Orders use the existing valid/busy request handshake. Every accepted order returns exactly one response on the valid/busy output channel, with an error flag.
- New versus `link_top`: insert by position, length query, table clear, old-data return on delete/change, and error reporting.

Parameters:
- DATA_WIDTH, 16, payload width.
- TABLE_WIDTH, 2, width of order_table.
- TABLE_NUM, 4, number of tables; must be ≤ 2**TABLE_WIDTH.
- DEPTH_WIDTH, 6, node index width; pool holds NODES = 2**DEPTH_WIDTH nodes.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- order_valid  input  1  order request.
- order_busy  output  1  manager cannot accept an order.
- order_type  input  3  0 APPE, 1 DELE, 2 CHAG, 3 READ, 4 LEN, 5 CLR; 6 and 7 are illegal.
- order_table  input  TABLE_WIDTH  table select.
- order_node  input  DEPTH_WIDTH+1  list position p, where 0 is the head.
- order_data  input  DATA_WIDTH  payload for APPE and CHAG.
- dout_valid  output  1  response valid.
- dout_busy  input  1  downstream stall.
- dout_data  output  DATA_WIDTH  response data.
- dout_err  output  1  order rejected; no state was changed.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values:
  - order_busy=0, dout_valid=0, dout_data=0, dout_err=0.
  - len[t]=0 and head[t]=0 for all tables.
  - alloc_ptr=0, free_cnt=0, state=IDLE.
  - Array contents are don't-care.
- Reset mid-operation aborts the order and empties every table. No response is issued.
- Acceptance: an order is accepted on a posedge where order_valid=1 and order_busy=0. order_busy is 1 in every state except IDLE. It is registered high on the acceptance edge.
- States: IDLE → CHECK → WALK → EXEC → RESP → IDLE.
  - CHECK validates the order and loads cursor=head[t], hop count H.
  - WALK follows one next pointer per cycle until H hops are done. It is skipped when H=0.
  - EXEC performs the array and register update.
  - RESP holds dout_valid=1, with dout_data and dout_err stable, until a posedge with dout_busy=0. It then returns to IDLE; order_busy falls on the same edge.
- Latency: with dout_busy=0, dout_valid rises at acceptance edge + 2 + H. Hop count H per order type:
  - READ and CHAG: H = p.
  - APPE and DELE: H = max(p−1, 0).
  - CLR: H = len.
  - LEN and any error: H = 0.
- Error checks, done in CHECK with the response given directly:
  - Illegal type.
  - Table index ≥ TABLE_NUM.
  - APPE with p > len.
  - DELE, CHAG or READ with p ≥ len.
  - APPE when the pool is exhausted (alloc_ptr==NODES and free_cnt==0).
  - Response on error: dout_err=1, dout_data=0.
- APPE:
  - Node source: the free-list head when free_cnt>0, otherwise alloc_ptr, which then increments. alloc_ptr is DEPTH_WIDTH+1 bits wide and saturates at NODES.
  - The new node becomes position p. p=0 rewrites head[t]; p=len links at the tail.
  - len increments. Response data is 0.
- DELE: unlinks position p. p=0 rewrites head[t]. The node is pushed onto the free list and free_cnt increments. len decrements. dout_data = removed data.
- CHAG: overwrites data at position p. dout_data = previous data.
- READ: dout_data = data at position p. No state change.
- LEN: dout_data = zero-extended len[t].
- CLR: WALK pushes each node onto the free list, one per cycle. Then len=0. dout_data = number of nodes freed.
- Simultaneous events: order_valid is ignored while busy. Allocation and free never occur in the same cycle.

Test Plan:
- Reset; APPE(3,0,111), APPE(3,1,112), APPE(3,2,113); LEN(3) → dout_data=3, err=0. Then READ(3,2) → 113, with dout_valid exactly 4 cycles after acceptance.
- DELE(3,2) → dout_data=113, len 2. Then APPE(1,0,20) reuses the freed node; READ(1,0) → 20; READ(3,1) → 112.
- APPE(2,0,5), APPE(2,0,6), APPE(2,1,7) → READ positions 0,1,2 return 6,7,5. Then CHG(2,1,9) → dout_data=7, and READ(2,1) → 9.
- Errors, each giving err=1, data=0, with a following LEN unchanged:
  - READ(0,0) on an empty table.
  - APPE(0,2,1) with len=0.
  - Type 7.
  - Table 3 with TABLE_NUM=3.
  - APPE after all 64 nodes are allocated.
- CLR(3) on 3 nodes → dout_data=3; LEN(3)=0. Then 3 APPEs succeed with no alloc_ptr growth.
- Hold dout_busy=1 for 5 cycles during a READ → dout_valid and dout_data stable, order_busy=1 throughout. Assert rst_n=0 mid-WALK → all outputs 0 and LEN of every table returns 0.
